// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared state encoding, Memory widths and requester port indices
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    localparam int AW_DEF = 7;
    localparam int DW_DEF = 32;

    localparam logic P_CPU = 1'b0;
    localparam logic P_AUX = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester req/ack handshakes plus the Memory control outputs
interface mem_bus_arbiter_if import mem_bus_arbiter_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          req0, we0, ack0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0, rdata0;
    logic          req1, we1, ack1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1, rdata1;
    logic          mem_cs, mem_we;
    logic [AW-1:0] mem_addr;
    logic [1:0]    grant;
    logic          busy;

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        input  ack0, rdata0, ack1, rdata1, mem_cs, mem_we, mem_addr, grant, busy
    );

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        output ack0, rdata0, ack1, rdata1, mem_cs, mem_we, mem_addr, grant, busy
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// mem_bus_arbiter_rr_pick2: combinational two-port round-robin or fixed-priority winner select
module mem_bus_arbiter_rr_pick2 import mem_bus_arbiter_pkg::*; #(
    parameter int FIXED_PRI = 0
) (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic winner_o,
    output logic valid_o
);

    assign valid_o  = req0_i | req1_i;
    assign winner_o = (req0_i && req1_i) ? ((FIXED_PRI != 0) ? P_CPU : ~last_grant_i) : req1_i;

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one Memory between two requesters, sequencing CS/WE/address
// and owning the Mem_Bus tristate drive
module mem_bus_arbiter import mem_bus_arbiter_pkg::*; #(
    parameter int ACC_CYC   = 2,
    parameter int FIXED_PRI = 0,
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    mem_bus_arbiter_if.slave arb,
    inout  wire [DW-1:0]     mem_bus
);

    localparam int CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          win_q, win_d, we_q, we_d, last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          pick_win, pick_valid, in_acc, in_ack, last_cyc, cap;

    mem_bus_arbiter_rr_pick2 #(.FIXED_PRI(FIXED_PRI)) u_pick (
        .req0_i       (arb.req0),
        .req1_i       (arb.req1),
        .last_grant_i (last_q),
        .winner_o     (pick_win),
        .valid_o      (pick_valid)
    );

    assign in_acc   = state_q == ST_ACCESS;
    assign in_ack   = state_q == ST_ACK;
    assign last_cyc = cnt_q == CW'(ACC_CYC - 1);
    assign cap      = in_acc && last_cyc && !we_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            win_q    <= P_CPU;
            we_q     <= 1'b0;
            last_q   <= P_AUX;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            we_q     <= we_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Operands are latched at grant so requesters may change them during ACCESS
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        we_d     = we_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = (cap && win_q == P_CPU) ? mem_bus : rdata0_q;
        rdata1_d = (cap && win_q == P_AUX) ? mem_bus : rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                    win_d   = pick_win;
                    last_d  = pick_win;
                    we_d    = pick_win ? arb.we1 : arb.we0;
                    addr_d  = pick_win ? arb.addr1 : arb.addr0;
                    wdata_d = pick_win ? arb.wdata1 : arb.wdata0;
                end
            end
            ST_ACCESS: begin
                state_d = last_cyc ? ST_ACK : ST_ACCESS;
                cnt_d   = last_cyc ? cnt_q : cnt_q + CW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign arb.mem_cs   = in_acc;
    assign arb.mem_we   = in_acc && we_q;
    assign arb.mem_addr = in_acc ? addr_q : '0;
    assign arb.grant    = (in_acc || in_ack) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    assign arb.busy     = in_acc || in_ack;
    assign arb.ack0     = in_ack && win_q == P_CPU;
    assign arb.ack1     = in_ack && win_q == P_AUX;
    assign arb.rdata0   = rdata0_q;
    assign arb.rdata1   = rdata1_q;

    // Only ACCESS-write cycles drive the bus; ACK always leaves a turnaround gap
    assign mem_bus = (in_acc && we_q) ? wdata_q : 'z;

endmodule
